icache_dm: RTL and testbench

- Parametrised direct-mapped L1 instruction cache.
- Sits between the pipelined CPU fetch stage and the shared system bus, so program memory no longer has to be a private on-chip array.
- Serves hits with 1-cycle registered latency.
- Refills whole lines over the word bus on a miss.
- Supports full invalidation for fence.i.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_data_ram.sv | 28 ++
 rtl/icache_dm.sv | 185 ++++++++++++++++++
 tb/tb_icache_dm.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state type and address-field width helpers for icache_dm.
// Revision: 1.0
`default_nettype none

package icache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    REFILL  = 2'd2,
    RESPOND = 2'd3
  } icache_state_e;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines, input int line_words);
    return addr_w - 2 - $clog2(num_lines) - $clog2(line_words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_data_ram.sv
// icache_data_ram: single-clock data array, one write port and one synchronous read port.
// Revision: 1.0
`default_nettype none

module icache_data_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped L1 instruction cache with whole-line refill and full invalidate.
// Optional hit/miss counters when ICACHE_PERF_EN is defined. Revision: 1.0
`default_nettype none

module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  input  logic              invalidate,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_ren,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_done
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses
`endif
);

  localparam int OFF_W  = offset_w(LINE_WORDS);
  localparam int IDX_W  = index_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
  localparam int RAM_AW = OFF_W + IDX_W;
  localparam int WA_W   = ADDR_W - 2;
  localparam int CNT_W  = (OFF_W > 0) ? OFF_W : 1;

  icache_state_e state, state_next;

  logic [WA_W-1:0]      req_wa;
  logic [CNT_W-1:0]     cnt;
  logic                 inv_seen;
  logic                 resp_pending;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];

  logic [WA_W-1:0]   fetch_wa;
  logic [RAM_AW-1:0] req_ram;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WA_W-1:0]   line_wa;
  logic [RAM_AW-1:0] ram_raddr, ram_waddr;
  logic [31:0]       ram_rdata;
  logic              ram_we;
  logic              hit, accept, last_word, miss_now;

  assign fetch_wa  = WA_W'(fetch_addr >> 2);
  assign req_ram   = req_wa[RAM_AW-1:0];
  assign req_idx   = req_wa[RAM_AW-1:OFF_W];
  assign req_tag   = req_wa[WA_W-1:RAM_AW];
  assign line_wa   = req_wa & ~WA_W'(LINE_WORDS - 1);
  assign last_word = (cnt == CNT_W'(LINE_WORDS - 1));

  // A same-cycle invalidate wins over the lookup.
  assign hit      = valid[req_idx] && (tags[req_idx] == req_tag) && !invalidate;
  assign miss_now = (state == LOOKUP) && !hit;
  assign accept   = fetch_req && fetch_ready;

  assign ram_we    = (state == REFILL) && bus_done;
  assign ram_waddr = (RAM_AW'(req_idx) << OFF_W) | RAM_AW'(cnt);

  assign fetch_valid = ((state == LOOKUP) && hit) || resp_pending;
  assign fetch_instr = fetch_valid ? ram_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    fetch_ready = 1'b0;
    ram_raddr   = fetch_wa[RAM_AW-1:0];
    case (state)
      IDLE: begin
        fetch_ready = 1'b1;
        if (fetch_req) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          fetch_ready = 1'b1;
          state_next  = fetch_req ? LOOKUP : IDLE;
        end else begin
          state_next = REFILL;
        end
      end
      REFILL: begin
        if (bus_done && last_word) state_next = RESPOND;
      end
      RESPOND: begin
        ram_raddr  = req_ram;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_wa       <= '0;
      cnt          <= '0;
      inv_seen     <= 1'b0;
      resp_pending <= 1'b0;
      bus_ren      <= 1'b0;
      bus_addr     <= '0;
    end else begin
      resp_pending <= (state == RESPOND);
      if (accept) begin
        req_wa <= fetch_wa;
      end
      if (miss_now) begin
        cnt      <= '0;
        inv_seen <= 1'b0;
        bus_ren  <= 1'b1;
        bus_addr <= {line_wa, 2'b00};
      end
      if (state == REFILL) begin
        if (invalidate) inv_seen <= 1'b1;
        if (bus_done) begin
          cnt <= cnt + CNT_W'(1);
          if (last_word) begin
            bus_ren <= 1'b0;
          end else begin
            bus_addr <= {line_wa | WA_W'(cnt + CNT_W'(1)), 2'b00};
          end
        end
      end
    end
  end

  // An invalidate seen at any point of the refill keeps the new line invalid.
  always_ff @(posedge clk) begin
    if (rst || invalidate) begin
      valid <= '0;
    end else if ((state == REFILL) && bus_done && last_word && !inv_seen) begin
      valid[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == REFILL) && bus_done && last_word) begin
      tags[req_idx] <= req_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if ((state == LOOKUP) && hit) perf_hits <= perf_hits + 32'd1;
      if (miss_now) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

  icache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .AW    (RAM_AW)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (bus_rdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed self-checking bench for icache_dm with a 2-cycle bus responder.
// Revision: 1.0
`default_nettype none

module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'd0;
  logic        fetch_ready, fetch_valid;
  logic [31:0] fetch_instr;
  logic        invalidate = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_ren;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_done = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ren_cycles = 0;
  int wcnt = 0;
  logic [31:0] log_a [0:255];

  always #5 clk = ~clk;

  icache_dm #(.NUM_LINES(64), .LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .invalidate  (invalidate),
    .bus_addr    (bus_addr),
    .bus_ren     (bus_ren),
    .bus_rdata   (bus_rdata),
    .bus_done    (bus_done)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
`endif
  );

  // Memory image: each word is 0xC0DE in the upper half and its byte address below.
  always @(posedge clk) begin
    bus_done <= 1'b0;
    if (bus_ren) ren_cycles <= ren_cycles + 1;
    if (rst) begin
      wcnt <= 0;
    end else if (bus_ren && !bus_done) begin
      if (wcnt == 1) begin
        bus_done  <= 1'b1;
        bus_rdata <= {16'hC0DE, bus_addr[15:0]};
        log_a[done_cnt[7:0]] <= bus_addr;
        done_cnt  <= done_cnt + 1;
        wcnt      <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_start(input logic [31:0] a);
    int t;
    fetch_req  = 1'b1;
    fetch_addr = a;
    t = 0;
    while (!fetch_ready && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) check("ready_timeout", 32'd1, 32'd0);
    step();
    fetch_req = 1'b0;
  endtask

  task automatic fetch_wait(output int lat);
    lat = 0;
    while (!fetch_valid && lat < 300) begin
      step();
      lat++;
    end
    if (lat >= 300) check("valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp, input int words);
    int n0, lat;
    n0 = done_cnt;
    fetch_start(a);
    fetch_wait(lat);
    check({tag, "_instr"}, fetch_instr, exp);
    step();
    check({tag, "_words"}, 32'(done_cnt - n0), 32'(words));
    if (words == 4) begin
      for (int k = 0; k < 4; k++) begin
        check({tag, "_busaddr"}, log_a[8'(n0 + k)], (a & 32'hFFFF_FFF0) + 32'(4 * k));
      end
    end else begin
      check({tag, "_hitlat"}, 32'(lat), 32'd0);
    end
  endtask

  initial begin
    int n0, t, lat;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_instr", fetch_instr, 32'd0);
    check("rst_ren", {31'd0, bus_ren}, 32'd0);
    check("rst_busaddr", bus_addr, 32'd0);
    check("rst_ready", {31'd0, fetch_ready}, 32'd1);
    rst = 1'b0;
    step();

    // Cold miss, then a hit on the same line with no bus traffic.
    fetch("cold", 32'h100, 32'hC0DE_0100, 4);
    t = ren_cycles;
    fetch("hit104", 32'h104, 32'hC0DE_0104, 0);
    check("hit_noren", 32'(ren_cycles - t), 32'd0);

    // Streaming: four back-to-back hits.
    t = ren_cycles;
    fetch_req  = 1'b1;
    fetch_addr = 32'h100;
    step();
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", {31'd0, fetch_valid}, 32'd1);
      check("stream_instr", fetch_instr, 32'hC0DE_0100 + 32'(4 * i));
      if (i < 3) fetch_addr = 32'h104 + 32'(4 * i);
      else fetch_req = 1'b0;
      step();
    end
    check("stream_noren", 32'(ren_cycles - t), 32'd0);

    // Conflict eviction on index 16.
    fetch("evict500", 32'h500, 32'hC0DE_0500, 4);
    fetch("evict100", 32'h100, 32'hC0DE_0100, 4);

    // Invalidate after a hit forces a full refill.
    fetch("prehit", 32'h100, 32'hC0DE_0100, 0);
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    fetch("postinv", 32'h100, 32'hC0DE_0100, 4);

    // Invalidate in the middle of a refill of 0x200.
    n0 = done_cnt;
    fetch_start(32'h208);
    t = 0;
    while (done_cnt < n0 + 2 && t < 200) begin
      step();
      t++;
    end
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    fetch_wait(lat);
    check("invref_instr", fetch_instr, 32'hC0DE_0208);
    step();
    check("invref_words", 32'(done_cnt - n0), 32'd4);
    fetch("after_invref", 32'h200, 32'hC0DE_0200, 4);

    // Reset in the middle of a refill.
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    n0 = done_cnt;
    fetch_start(32'h100);
    t = 0;
    while (done_cnt < n0 + 2 && t < 200) begin
      step();
      t++;
    end
    check("pre_rst_ren", {31'd0, bus_ren}, 32'd1);
    rst = 1'b1;
    step();
    check("midrst_ren", {31'd0, bus_ren}, 32'd0);
    check("midrst_ready", {31'd0, fetch_ready}, 32'd1);
    check("midrst_valid", {31'd0, fetch_valid}, 32'd0);
    rst = 1'b0;
    step();
    fetch("rst_refill", 32'h100, 32'hC0DE_0100, 4);

`ifdef ICACHE_PERF_EN
    fetch("perf_h1", 32'h104, 32'hC0DE_0104, 0);
    fetch("perf_h2", 32'h108, 32'hC0DE_0108, 0);
    fetch("perf_h3", 32'h10C, 32'hC0DE_010C, 0);
    check("perf_hits", perf_hits, 32'd3);
    check("perf_misses", perf_misses, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("perf_hits_rst", perf_hits, 32'd0);
    check("perf_misses_rst", perf_misses, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
